mul32_seq_ctrl: RTL

- Multi-cycle unsigned 32x32 -> 64-bit shift-add multiplier controller.
- Owns no adder. It sequences one external 32-bit adder-with-carry: S[32:0] = A + (B + c0).
- Sits beside the ALU. The CPU pulses start, polls ready/done, and reads product for MULTU/MFHI/MFLO.
- Sharing the existing adder keeps area at a single 32-bit adder.

---
 rtl/mul32_seq_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/mul32_seq_ctrl.sv
// Sequential unsigned 32x32 -> 64 shift-add multiplier controller.
// Drives one shared external 33-bit adder; owns no arithmetic of its own.
module mul32_seq_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   output logic               add_c0,
   input  logic [WIDTH:0]     add_s
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mcand_nxt;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] lo_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load;

   // Next-state and datapath update; one shift-add iteration per BUSY cycle.
   always_comb begin
      state_nxt = state;
      mcand_nxt = mcand;
      hi_nxt    = hi;
      lo_nxt    = lo;
      cnt_nxt   = cnt;
      load      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               load = 1'b1;
            end
         end
         BUSY: begin
            {hi_nxt, lo_nxt} = {add_s, lo[WIDTH-1:1]};
            cnt_nxt          = cnt + CNT_W'(1);
            if (cnt == LAST_ITER) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (load) begin
         mcand_nxt = a;
         hi_nxt    = '0;
         lo_nxt    = b;
         cnt_nxt   = '0;
         state_nxt = BUSY;
      end
   end

   // Adder operands are registered from next-state values so the shared
   // adder sees exactly hi / (lo[0] ? mcand : 0) in BUSY and zeros elsewhere.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         add_a <= '0;
         add_b <= '0;
      end else begin
         state <= state_nxt;
         mcand <= mcand_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         cnt   <= cnt_nxt;
         ready <= (state_nxt != BUSY);
         busy  <= (state_nxt == BUSY);
         done  <= (state_nxt == DONE);
         add_a <= (state_nxt == BUSY) ? hi_nxt : '0;
         add_b <= ((state_nxt == BUSY) && lo_nxt[0]) ? mcand_nxt : '0;
      end
   end

   assign product = {hi, lo};
   assign add_c0  = 1'b0;

endmodule
